// File: rtl/pipeline_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stage_chain
// Purpose  : Elastic DEPTH-stage payload pipeline with per-stage stall/flush,
//            step gating, debug tap and retire/stall performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stage_chain #(
  parameter int NB     = 32,
  parameter int DEPTH  = 5,
  parameter int NB_IDX = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_step,
  input  logic              i_in_valid,
  input  logic [NB-1:0]     i_in_data,
  output logic              o_in_ready,
  input  logic [DEPTH-1:0]  i_stall,
  input  logic [DEPTH-1:0]  i_flush,
  output logic              o_out_valid,
  output logic [NB-1:0]     o_out_data,
  input  logic              i_out_ready,
  output logic [DEPTH-1:0]  o_valid,
  input  logic [NB_IDX-1:0] i_debug_stage,
  output logic [NB-1:0]     o_debug_data,
  output logic [31:0]       o_retired_count,
  output logic [15:0]       o_stall_count
);

  logic [NB-1:0]    data_q [DEPTH];
  logic [NB-1:0]    data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DEPTH-1:0] valid_eff;
  logic [DEPTH-1:0] adv;
  logic [DEPTH:0]   ready;
  logic [31:0]      retired_q;
  logic [31:0]      retired_d;
  logic [15:0]      stall_cnt_q;
  logic [15:0]      stall_cnt_d;

  // Ready resolves from the consumer back toward stage 0.
  always_comb begin
    valid_eff    = valid_q & ~i_flush;
    ready        = '0;
    adv          = '0;
    ready[DEPTH] = i_out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = ~i_stall[k] & (~valid_eff[k] | ready[k+1]);
      adv[k]   = valid_eff[k] & ~i_stall[k] & ready[k+1];
    end
  end

  always_comb begin
    valid_d     = valid_q;
    data_d      = data_q;
    retired_d   = retired_q;
    stall_cnt_d = stall_cnt_q;
    if (i_step) begin
      if (i_in_valid && ready[0]) begin
        data_d[0]  = i_in_data;
        valid_d[0] = 1'b1;
      end else if (adv[0] || i_flush[0]) begin
        valid_d[0] = 1'b0;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (adv[k-1]) begin
          data_d[k]  = data_q[k-1];
          valid_d[k] = 1'b1;
        end else if (adv[k] || i_flush[k]) begin
          valid_d[k] = 1'b0;
        end
      end
      if (adv[DEPTH-1]) begin
        retired_d = retired_q + 32'd1;
      end
      if (|(valid_eff & ~adv) && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  always_comb begin
    o_debug_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (i_debug_stage == NB_IDX'(k)) begin
        o_debug_data = data_q[k];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      valid_q     <= '0;
      data_q      <= '{default: '0};
      retired_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      data_q      <= data_d;
      retired_q   <= retired_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_in_ready      = ready[0];
  assign o_out_valid     = valid_eff[DEPTH-1] & ~i_stall[DEPTH-1];
  assign o_out_data      = data_q[DEPTH-1];
  assign o_valid         = valid_q;
  assign o_retired_count = retired_q;
  assign o_stall_count   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stage_chain
// Purpose  : Directed scoreboard bench for pipeline_stage_chain (DEPTH=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stage_chain;
  localparam int NB     = 32;
  localparam int DEPTH  = 5;
  localparam int NB_IDX = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              step = 1'b1;
  logic              in_valid = 1'b0;
  logic [NB-1:0]     in_data = '0;
  logic              in_ready;
  logic [DEPTH-1:0]  stall = '0;
  logic [DEPTH-1:0]  flush = '0;
  logic              out_valid;
  logic [NB-1:0]     out_data;
  logic              out_ready = 1'b1;
  logic [DEPTH-1:0]  valid;
  logic [NB_IDX-1:0] dbg = '0;
  logic [NB-1:0]     dbg_data;
  logic [31:0]       retired;
  logic [15:0]       stall_cnt;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  pipeline_stage_chain #(.NB(NB), .DEPTH(DEPTH), .NB_IDX(NB_IDX)) dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_step         (step),
    .i_in_valid     (in_valid),
    .i_in_data      (in_data),
    .o_in_ready     (in_ready),
    .i_stall        (stall),
    .i_flush        (flush),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .i_out_ready    (out_ready),
    .o_valid        (valid),
    .i_debug_stage  (dbg),
    .o_debug_data   (dbg_data),
    .o_retired_count(retired),
    .o_stall_count  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: a transfer is decided mid-cycle, ahead of the edge that commits it.
  always @(negedge clk) begin
    if (rst_n && step && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_extra: got 0x%08h expected no item", out_data);
      end else begin
        chk("out_data", out_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_item(input logic [31:0] d, input bit expect_out);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_out) exp_q.push_back(d);
    tick();
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_data = '0; stall = '0; flush = '0;
    out_ready = 1'b1; step = 1'b1; dbg = '0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("rst_valid", {27'd0, valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_counts", retired | {16'd0, stall_cnt}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Continuous stream, latency and throughput.
    for (int i = 0; i < 7; i++) begin
      push_item(32'h11 * (i + 1), 1'b1);
      if (i == 3) chk("t1_lat_not_yet", {31'd0, out_valid}, 32'd0);
      if (i == 4) chk("t1_lat_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    ticks(6);
    chk("t1_retired", retired, 32'd7);
    chk("t1_stall", {16'd0, stall_cnt}, 32'd0);
    chk("t1_drained", exp_q.size(), 32'd0);

    // Full pipeline with back-pressure.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_item(32'hA1 + i, 1'b1);
    in_valid = 1'b0;
    #1;
    chk("t2_full", {27'd0, valid}, 32'h1F);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t2_out_data", out_data, 32'hA1);
    ticks(3);
    chk("t2_out_hold", out_data, 32'hA1);
    chk("t2_stall", {16'd0, stall_cnt}, 32'd3);
    chk("t2_still_full", {27'd0, valid}, 32'h1F);
    out_ready = 1'b1;
    ticks(6);
    chk("t2_retired", retired, 32'd5);
    chk("t2_drained", exp_q.size(), 32'd0);

    // Mid-pipeline stall inserts bubbles downstream.
    do_reset();
    for (int i = 0; i < 5; i++) push_item(32'hB1 + i, 1'b1);
    in_valid = 1'b0;
    stall = 5'b00100;
    tick();
    chk("t3_bubble1", {27'd0, valid}, 32'h17);
    tick();
    chk("t3_bubble2", {27'd0, valid}, 32'h07);
    chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_stall", {16'd0, stall_cnt}, 32'd2);
    stall = '0;
    push_item(32'hB6, 1'b1);
    push_item(32'hB7, 1'b1);
    in_valid = 1'b0;
    ticks(8);
    chk("t3_retired", retired, 32'd7);
    chk("t3_stall_after", {16'd0, stall_cnt}, 32'd2);
    chk("t3_drained", exp_q.size(), 32'd0);

    // Flush of the two youngest items in a full pipeline.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_item(32'hC1 + i, i < 3);
    in_valid = 1'b0;
    flush = 5'b00011;
    tick();
    chk("t4_after_flush", {27'd0, valid}, 32'h1C);
    chk("t4_stall", {16'd0, stall_cnt}, 32'd1);
    flush = '0;
    out_ready = 1'b1;
    ticks(6);
    chk("t4_retired", retired, 32'd3);
    chk("t4_drained", exp_q.size(), 32'd0);

    // Step gating freezes everything.
    do_reset();
    for (int i = 0; i < 3; i++) push_item(32'hD1 + i, 1'b1);
    step = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hD9;
    flush = 5'h1F;
    ticks(4);
    chk("t5_valid_frozen", {27'd0, valid}, 32'h07);
    chk("t5_retired_frozen", retired, 32'd0);
    chk("t5_stall_frozen", {16'd0, stall_cnt}, 32'd0);
    flush = '0;
    #1;
    chk("t5_stage0", dbg_data, 32'hD3);
    step = 1'b1;
    in_valid = 1'b0;
    ticks(8);
    chk("t5_retired", retired, 32'd3);
    chk("t5_drained", exp_q.size(), 32'd0);

    // Asynchronous reset mid-stream.
    do_reset();
    for (int i = 0; i < 7; i++) push_item(32'hE1 + i, 1'b1);
    in_valid = 1'b0;
    chk("t6_pre_retired", retired, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {27'd0, valid}, 32'd0);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_dbg", dbg_data, 32'd0);
    chk("t6_retired", retired, 32'd0);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    tick();
    rst_n = 1'b1;

    // Debug tap and stall counter saturation.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_item(32'hF1 + i, 1'b1);
    in_valid = 1'b0;
    dbg = 3'd3;
    #1;
    chk("t7_dbg3", dbg_data, 32'hF2);
    dbg = 3'd6;
    #1;
    chk("t7_dbg6", dbg_data, 32'd0);
    dbg = 3'd0;
    #1;
    chk("t7_dbg0", dbg_data, 32'hF5);
    chk("t7_stall0", {16'd0, stall_cnt}, 32'd0);
    ticks(65534);
    chk("t7_stall_fffe", {16'd0, stall_cnt}, 32'hFFFE);
    tick();
    chk("t7_stall_ffff", {16'd0, stall_cnt}, 32'hFFFF);
    ticks(3);
    chk("t7_stall_sat", {16'd0, stall_cnt}, 32'hFFFF);
    out_ready = 1'b1;
    ticks(6);
    chk("t7_retired", retired, 32'd5);
    chk("t7_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
